// File: rtl/rv_mon_pkg.sv
// rv_mon_pkg: shared types and decode helpers for the rv_test_monitor slice.
//   mon_state_e   - monitor FSM states (RUN, DRAIN, DONE)
//   OPC_SYSTEM    - SYSTEM major opcode
//   IMM_ECALL/IMM_EBREAK - imm[11:0] values selecting ECALL / EBREAK
//   is_halt_inst  - true when a retiring instruction is ECALL or EBREAK
package rv_mon_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } mon_state_e;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [11:0] IMM_ECALL  = 12'h000;
    localparam logic [11:0] IMM_EBREAK = 12'h001;

    function automatic logic is_halt_inst(input logic valid, input logic [31:0] inst);
        return valid
            && (inst[6:0] == OPC_SYSTEM)
            && (inst[14:12] == 3'b000)
            && ((inst[31:20] == IMM_ECALL) || (inst[31:20] == IMM_EBREAK));
    endfunction

endpackage

// File: rtl/rv_sat_counter.sv
// rv_sat_counter: W-bit up-counter that sticks at all-ones.
//   clk     - rising-edge clock
//   clr_i   - synchronous clear (dominates enable)
//   en_i    - count enable
//   count_o - current count
module rv_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/rv_test_monitor.sv
// rv_test_monitor: watches a RISC-V core under test and reports the
// riscv-tests style result (x3 == 1 means pass, else failing test = x3>>1).
//   clk, rst                       - clock, synchronous active-high reset
//   retire_valid/retire_inst       - retire port; ECALL/EBREAK halts the test
//   gp_value                       - architectural x3 at retire
//   mem_wr_valid/addr/data         - data-memory store port (tohost)
//   done, pass, fail, timeout      - result status
//   test_num                       - failing test number
//   cycle_count, instret_count     - saturating performance counters
// Build option: define RV_MON_TOHOST_EN to treat odd stores to TOHOST_ADDR
// as halt events (store data takes priority over gp_value on the same cycle).
module rv_test_monitor #(
    parameter int unsigned    XLEN           = 32,
    parameter int unsigned    CNT_W          = 32,
    parameter int unsigned    TIMEOUT_CYCLES = 10000,
    parameter int unsigned    DRAIN_CYCLES   = 2,
    parameter logic [XLEN-1:0] TOHOST_ADDR   = XLEN'(32'h0000_1000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire_valid,
    input  logic [31:0]      retire_inst,
    input  logic [XLEN-1:0]  gp_value,
    input  logic             mem_wr_valid,
    input  logic [XLEN-1:0]  mem_wr_addr,
    input  logic [XLEN-1:0]  mem_wr_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  test_num,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    import rv_mon_pkg::*;

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    // Compare width for the timeout check: never narrower than the parameter,
    // so a small counter cannot alias a large budget.
    localparam int unsigned TW = (CNT_W > 32) ? CNT_W : 32;

    mon_state_e      state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            pass_q, pass_d;
    logic            fail_q, fail_d;
    logic            tmo_q, tmo_d;
    logic [XLEN-1:0] tnum_q, tnum_d;

    logic            halt_ev;
    logic [XLEN-1:0] result_val;
    logic            tmo_hit;
    logic            cyc_en;
    logic            ins_en;

`ifdef RV_MON_TOHOST_EN
    logic tohost_ev;
    assign tohost_ev  = mem_wr_valid && (mem_wr_addr == TOHOST_ADDR) && mem_wr_data[0];
    assign halt_ev    = tohost_ev || is_halt_inst(retire_valid, retire_inst);
    assign result_val = tohost_ev ? mem_wr_data : gp_value;
`else
    logic unused_mem_wr;
    assign unused_mem_wr = ^{mem_wr_valid, mem_wr_addr, mem_wr_data};
    assign halt_ev       = is_halt_inst(retire_valid, retire_inst);
    assign result_val    = gp_value;
`endif

    assign tmo_hit = (TW'(cycle_count) == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        tnum_d  = tnum_q;
        case (state_q)
            ST_RUN: begin
                if (halt_ev) begin
                    pass_d = (result_val == XLEN'(1));
                    fail_d = !pass_d;
                    tmo_d  = 1'b0;
                    tnum_d = pass_d ? '0 : (result_val >> 1);
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DW'(DRAIN_CYCLES - 1);
                    end
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                    tmo_d   = 1'b1;
                    fail_d  = 1'b1;
                    pass_d  = 1'b0;
                    tnum_d  = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            drain_q <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
            tnum_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            tnum_q  <= tnum_d;
        end
    end

    // The forced-timeout edge jumps straight to DONE, so it does not count.
    assign cyc_en = ((state_q == ST_RUN) && !(tmo_hit && !halt_ev)) || (state_q == ST_DRAIN);
    assign ins_en = (state_q == ST_RUN) && retire_valid;

    rv_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .en_i    (cyc_en),
        .count_o (cycle_count)
    );

    rv_sat_counter #(.W(CNT_W)) u_instret_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .en_i    (ins_en),
        .count_o (instret_count)
    );

    assign done     = (state_q == ST_DONE);
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign timeout  = tmo_q;
    assign test_num = tnum_q;

endmodule

// File: tb/tb_rv_test_monitor.sv
// tb_rv_test_monitor: randomized episodes against a cycle-list reference
// model; expected results go into a scoreboard queue that a separate
// monitor process drains when the DUT raises its result flags and done.
module tb_rv_test_monitor;

    localparam int unsigned TMO = 100;
    localparam int unsigned DRN = 2;
    localparam logic [31:0] TH  = 32'h0000_1000;
    localparam logic [31:0] ECALL_I  = 32'h0000_0073;
    localparam logic [31:0] EBREAK_I = 32'h0010_0073;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rv = 1'b0, mv = 1'b0;
    logic [31:0] inst = '0, gp = '0, ma = '0, md = '0;
    logic        done, pass, fail, tmo;
    logic [31:0] tnum, cyc, ins;

    rv_test_monitor #(
        .XLEN(32), .CNT_W(32), .TIMEOUT_CYCLES(TMO), .DRAIN_CYCLES(DRN), .TOHOST_ADDR(TH)
    ) dut (
        .clk(clk), .rst(rst), .retire_valid(rv), .retire_inst(inst), .gp_value(gp),
        .mem_wr_valid(mv), .mem_wr_addr(ma), .mem_wr_data(md),
        .done(done), .pass(pass), .fail(fail), .timeout(tmo), .test_num(tnum),
        .cycle_count(cyc), .instret_count(ins)
    );

    logic        s_rst = 1'b1, s_rv = 1'b0;
    logic [31:0] s_inst = 32'h13;
    logic        s_done, s_pass, s_fail, s_tmo;
    logic [31:0] s_tnum;
    logic [3:0]  s_cyc, s_ins;

    rv_test_monitor #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(s_rst), .retire_valid(s_rv), .retire_inst(s_inst), .gp_value(32'd0),
        .mem_wr_valid(1'b0), .mem_wr_addr(32'd0), .mem_wr_data(32'd0),
        .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_tmo), .test_num(s_tnum),
        .cycle_count(s_cyc), .instret_count(s_ins)
    );

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    int edge_no = 0;
    always @(posedge clk) edge_no <= rst ? 0 : edge_no + 1;

    logic        a_rv[256];
    logic        a_mv[256];
    logic [31:0] a_inst[256], a_gp[256], a_ma[256], a_md[256];

    typedef struct {
        int          flag_edge;
        int          done_edge;
        bit          p, f, t;
        logic [31:0] tn, cy, in;
        bit          aborted;
    } exp_t;

    exp_t sb[$];

    // Walk the cycle list: first halt wins; otherwise the budget runs out on
    // cycle TMO-1. Results appear on the edge after the deciding cycle.
    function automatic exp_t model();
        exp_t        e;
        int          n_ret = 0;
        logic [31:0] v;
        e = '{default: 0};
        for (int t = 0; t < int'(TMO); t++) begin
            logic [31:0] w = a_inst[t];
            bit ecall = a_rv[t] && (w[6:0] == 7'h73) && (w[14:12] == 3'd0) && (w[31:20] < 12'd2);
            bit th = 1'b0;
`ifdef RV_MON_TOHOST_EN
            th = a_mv[t] && (a_ma[t] == TH) && a_md[t][0];
`endif
            if (a_rv[t]) n_ret++;
            if (ecall || th) begin
                v = th ? a_md[t] : a_gp[t];
                e.p = (v == 32'd1);
                e.f = !e.p;
                e.t = 1'b0;
                e.tn = e.p ? 32'd0 : v / 2;
                e.flag_edge = t + 1;
                e.done_edge = t + 1 + int'(DRN);
                e.cy = 32'(t + 1 + int'(DRN));
                e.in = 32'(n_ret);
                return e;
            end
            if (t == int'(TMO) - 1) begin
                e.p = 1'b0; e.f = 1'b1; e.t = 1'b1; e.tn = 32'd0;
                e.flag_edge = t + 1;
                e.done_edge = t + 1;
                e.cy = 32'(t);
                e.in = 32'(n_ret);
            end
        end
        return e;
    endfunction

    task automatic gen(input int h, input bit eb, input logic [31:0] g);
        for (int t = 0; t < 256; t++) begin
            int unsigned k = $urandom_range(0, 7);
            a_rv[t]   = 1'($urandom_range(0, 1));
            a_inst[t] = $urandom;
            a_gp[t]   = $urandom;
            if (k == 0) begin
                a_inst[t] = ECALL_I;
                a_rv[t]   = 1'b0;
            end else if (k == 1) begin
                a_inst[t] = 32'h0020_0073;
            end else if (k == 2) begin
                a_inst[t] = 32'h0000_1073;
            end
            a_mv[t] = ($urandom_range(0, 3) == 0);
            a_ma[t] = ($urandom_range(0, 1) == 1) ? TH : $urandom;
            a_md[t] = $urandom & 32'hFFFF_FFFE;
            if (t == h) begin
                a_rv[t]   = 1'b1;
                a_inst[t] = eb ? EBREAK_I : ECALL_I;
                a_gp[t]   = g;
            end
        end
    endtask

    task automatic idle_inputs();
        rv = 1'b0; mv = 1'b0; inst = '0; gp = '0; ma = '0; md = '0;
    endtask

    task automatic check_zero(input string pfx);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_pass"}, pass, 0);
        chk({pfx, "_fail"}, fail, 0);
        chk({pfx, "_timeout"}, tmo, 0);
        chk({pfx, "_test_num"}, tnum, 0);
        chk({pfx, "_cycle"}, cyc, 0);
        chk({pfx, "_instret"}, ins, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
    endtask

    task automatic run_episode(input bit abort);
        exp_t e;
        int   last;
        do_reset();
        e = model();
        e.aborted = abort;
        sb.push_back(e);
        last = abort ? e.flag_edge - 1 : e.done_edge + 8;
        for (int t = 0; t <= last; t++) begin
            rv = a_rv[t]; inst = a_inst[t]; gp = a_gp[t];
            mv = a_mv[t]; ma = a_ma[t]; md = a_md[t];
            @(posedge clk);
            #1;
        end
        if (abort) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            check_zero("drain_rst");
            rst = 1'b0;
            idle_inputs();
            @(posedge clk);
            #1;
            chk("after_rst_cycle", cyc, 1);
            chk("after_rst_done", done, 0);
        end
        while (sb.size() > 0) begin
            exp_t r = sb.pop_front();
            if (!r.aborted) begin
                checks++;
                errs++;
                $display("FAIL done_rise: done never rose, expected at edge %0d", r.done_edge);
            end
        end
    endtask

    // Monitor: compares on result-flag rise and done rise, then re-checks
    // that everything stays frozen a few cycles later.
    bit   prev_f = 1'b0, prev_d = 1'b0;
    int   frz = 0;
    exp_t hold;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                frz = 0;
            end else begin
                if ((pass | fail) && !prev_f) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL flag_rise: flags set at edge %0d, none expected", edge_no);
                    end else begin
                        chk("flag_edge", edge_no, sb[0].flag_edge);
                    end
                end
                if (done && !prev_d) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL done_rise: done at edge %0d, none expected", edge_no);
                    end else begin
                        hold = sb.pop_front();
                        chk("done_edge", edge_no, hold.done_edge);
                        chk("pass", pass, hold.p);
                        chk("fail", fail, hold.f);
                        chk("timeout", tmo, hold.t);
                        chk("test_num", tnum, hold.tn);
                        chk("cycle_count", cyc, hold.cy);
                        chk("instret_count", ins, hold.in);
                        chk("pass_xor_fail", pass ^ fail, 1);
                        frz = 4;
                    end
                end else if (frz > 0) begin
                    frz--;
                    if (frz == 0) begin
                        chk("frozen_done", done, 1);
                        chk("frozen_pass", pass, hold.p);
                        chk("frozen_timeout", tmo, hold.t);
                        chk("frozen_test_num", tnum, hold.tn);
                        chk("frozen_cycle", cyc, hold.cy);
                        chk("frozen_instret", ins, hold.in);
                    end
                end
            end
            prev_f = pass | fail;
            prev_d = done;
        end
    end

    initial begin
        gen(50, 1'b0, 32'd1);   run_episode(1'b0);
        gen(30, 1'b1, 32'd7);   run_episode(1'b0);
        gen(999, 1'b0, 32'd0);  run_episode(1'b0);
        gen(99, 1'b0, 32'd4);   run_episode(1'b0);
        gen(10, 1'b0, 32'd1);   run_episode(1'b1);
`ifdef RV_MON_TOHOST_EN
        gen(999, 1'b0, 32'd0);
        a_mv[5] = 1'b1;  a_ma[5] = TH;  a_md[5] = 32'd2;
        a_mv[20] = 1'b1; a_ma[20] = TH; a_md[20] = 32'd5;
        run_episode(1'b0);
        gen(30, 1'b0, 32'd9);
        a_mv[30] = 1'b1; a_ma[30] = TH; a_md[30] = 32'd1;
        run_episode(1'b0);
`endif
        for (int i = 0; i < 20; i++) begin
            gen(int'($urandom_range(0, 120)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? 32'd1 : 32'($urandom));
            run_episode(1'b0);
        end

        s_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        s_rst = 1'b0;
        s_rv  = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("small_instret_10", s_ins, 10);
        repeat (10) @(posedge clk);
        #1;
        chk("small_instret_sat", s_ins, 15);
        chk("small_cycle_sat", s_cyc, 15);
        chk("small_no_timeout", s_done, 0);
        s_rv = 1'b0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
